// File: rtl/pio_irq_scheduler.sv
// pio_irq_scheduler
//
// Avalon-MM input controller for sensor and limit-switch lines. Each channel
// is passed through a 2-FF synchronizer and a per-channel debounce counter.
// The debounced level is edge-captured with selectable polarity. Pending
// captures are gated by a per-channel mask and scheduled by fixed priority,
// lowest index first. A single registered level interrupt goes to the HPS.
//
// Ports:
//   clk          system clock; every flop is in this domain
//   reset        synchronous, active-high reset
//   address      Avalon-MM word address (0..7)
//   chipselect   slave select
//   write_n      active-low write strobe
//   writedata    write data
//   readdata     registered read data, one cycle of read latency
//   in_port      raw asynchronous input lines, one per channel
//   irq          registered level interrupt, high while any masked capture is set
//
// Register map (word address):
//   0 DATA      RO   debounced stable level
//   1 CAPTURE   W1C  edge-capture bits
//   2 MASK      RW   per-channel interrupt enable
//   3 PENDING   RO   bit31 = valid, [4:0] = lowest pending channel
//   4 THRESH    RW   debounce threshold
//   5 EDGE_CFG  RW   0 = capture rising, 1 = capture falling
//   6,7              read 0, writes ignored

module pio_irq_scheduler #(
  parameter int unsigned N          = 8,
  parameter int unsigned DB_W       = 16,
  parameter int unsigned DB_DEFAULT = 1000
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [2:0]   address,
  input  logic         chipselect,
  input  logic         write_n,
  input  logic [31:0]  writedata,
  output logic [31:0]  readdata,
  input  logic [N-1:0] in_port,
  output logic         irq
);

  localparam logic [2:0] AddrData    = 3'd0;
  localparam logic [2:0] AddrCapture = 3'd1;
  localparam logic [2:0] AddrMask    = 3'd2;
  localparam logic [2:0] AddrPending = 3'd3;
  localparam logic [2:0] AddrThresh  = 3'd4;
  localparam logic [2:0] AddrEdgeCfg = 3'd5;

  // State
  logic [N-1:0]    sync1_q, sync1_d;
  logic [N-1:0]    sync2_q, sync2_d;
  logic [N-1:0]    stable_q, stable_d;
  logic [DB_W-1:0] cnt_q [N];
  logic [DB_W-1:0] cnt_d [N];
  logic [N-1:0]    capture_q, capture_d;
  logic [N-1:0]    mask_q, mask_d;
  logic [N-1:0]    edge_cfg_q, edge_cfg_d;
  logic [DB_W-1:0] thresh_q, thresh_d;
  logic [31:0]     readdata_q, readdata_d;
  logic            irq_q, irq_d;

  // Combinational helpers
  logic            wr;
  logic [N-1:0]    edge_set;
  logic [N-1:0]    w1c;
  logic [N-1:0]    pend_vec;
  logic            pend_valid;
  logic [4:0]      pend_idx;

  // Only the low bits of writedata reach any register; fold the rest here.
  logic            unused_writedata;
  assign unused_writedata = ^writedata;

  assign wr = chipselect & ~write_n;

  //--------------------------------------------------------------------------
  // Synchronizer
  //--------------------------------------------------------------------------
  always_comb begin
    sync1_d = in_port;
    sync2_d = sync1_q;
  end

  //--------------------------------------------------------------------------
  // Debounce: a mismatch between the synchronized input and the stable level
  // must persist for thresh+1 consecutive cycles before stable follows it.
  // The counter never passes thresh, so it cannot wrap; if thresh is lowered
  // below the running count, the next mismatch cycle updates stable.
  //--------------------------------------------------------------------------
  always_comb begin
    stable_d = stable_q;
    for (int i = 0; i < int'(N); i++) begin
      cnt_d[i] = cnt_q[i];
      if (sync2_q[i] == stable_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] >= thresh_q) begin
        stable_d[i] = sync2_q[i];
        cnt_d[i]    = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + DB_W'(1);
      end
    end
  end

  //--------------------------------------------------------------------------
  // Edge capture: set in the same cycle stable changes in the selected
  // direction. A set overrides a same-cycle W1C of that bit.
  //--------------------------------------------------------------------------
  always_comb begin
    edge_set  = (~edge_cfg_q & stable_d & ~stable_q) |
                ( edge_cfg_q & ~stable_d & stable_q);
    w1c       = (wr && (address == AddrCapture)) ? writedata[N-1:0] : '0;
    capture_d = (capture_q & ~w1c) | edge_set;
  end

  //--------------------------------------------------------------------------
  // Configuration registers
  //--------------------------------------------------------------------------
  always_comb begin
    mask_d     = mask_q;
    edge_cfg_d = edge_cfg_q;
    thresh_d   = thresh_q;
    if (wr) begin
      case (address)
        AddrMask:    mask_d     = writedata[N-1:0];
        AddrThresh:  thresh_d   = writedata[DB_W-1:0];
        AddrEdgeCfg: edge_cfg_d = writedata[N-1:0];
        default:     ;
      endcase
    end
  end

  //--------------------------------------------------------------------------
  // Fixed-priority scheduler: scan from the top so the lowest set index is
  // the last one written and therefore wins.
  //--------------------------------------------------------------------------
  always_comb begin
    pend_vec   = capture_q & mask_q;
    pend_valid = |pend_vec;
    pend_idx   = '0;
    for (int i = int'(N) - 1; i >= 0; i--) begin
      if (pend_vec[i]) begin
        pend_idx = 5'(i);
      end
    end
  end

  //--------------------------------------------------------------------------
  // Read mux and interrupt, both registered
  //--------------------------------------------------------------------------
  always_comb begin
    readdata_d = '0;
    case (address)
      AddrData:    readdata_d[N-1:0]    = stable_q;
      AddrCapture: readdata_d[N-1:0]    = capture_q;
      AddrMask:    readdata_d[N-1:0]    = mask_q;
      AddrPending: readdata_d           = {pend_valid, 26'b0, pend_idx};
      AddrThresh:  readdata_d[DB_W-1:0] = thresh_q;
      AddrEdgeCfg: readdata_d[N-1:0]    = edge_cfg_q;
      default:     readdata_d           = '0;
    endcase
    irq_d = pend_valid;
  end

  //--------------------------------------------------------------------------
  // State register
  //--------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      stable_q   <= '0;
      for (int i = 0; i < int'(N); i++) begin
        cnt_q[i] <= '0;
      end
      capture_q  <= '0;
      mask_q     <= '0;
      edge_cfg_q <= '0;
      thresh_q   <= DB_W'(DB_DEFAULT);
      readdata_q <= '0;
      irq_q      <= 1'b0;
    end else begin
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      stable_q   <= stable_d;
      for (int i = 0; i < int'(N); i++) begin
        cnt_q[i] <= cnt_d[i];
      end
      capture_q  <= capture_d;
      mask_q     <= mask_d;
      edge_cfg_q <= edge_cfg_d;
      thresh_q   <= thresh_d;
      readdata_q <= readdata_d;
      irq_q      <= irq_d;
    end
  end

  assign readdata = readdata_q;
  assign irq      = irq_q;

endmodule

// File: tb/tb_pio_irq_scheduler.sv
// Self-checking bench for pio_irq_scheduler: a reset read-back table,
// hand-written multi-cycle sequences with fixed expectations, and a random
// phase. A behavioural model shadows every cycle and checks readdata and irq.

module tb_pio_irq_scheduler;

  localparam int unsigned N          = 8;
  localparam int unsigned DB_W       = 16;
  localparam int unsigned DB_DEFAULT = 1000;

  logic         clk = 1'b0;
  logic         reset;
  logic [2:0]   address;
  logic         chipselect;
  logic         write_n;
  logic [31:0]  writedata;
  logic [31:0]  readdata;
  logic [N-1:0] in_port;
  logic         irq;

  always #5 clk = ~clk;

  pio_irq_scheduler #(
    .N          (N),
    .DB_W       (DB_W),
    .DB_DEFAULT (DB_DEFAULT)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .in_port    (in_port),
    .irq        (irq)
  );

  int n_vec = 0;
  int n_err = 0;
  logic [N-1:0] cur_in = '0;

  // Behavioural model state
  logic [N-1:0] m_stable, m_cap, m_mask, m_edge;
  int unsigned  m_thresh;
  int unsigned  m_run [N];       // consecutive mismatch cycles seen so far
  logic [N-1:0] m_hist [$];      // in_port history; front is what debounce sees
  logic [31:0]  m_rd;
  logic         m_irq;

  typedef struct packed {
    logic [2:0]  addr;
    logic [31:0] exp;
  } vec_t;
  vec_t tab [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, required 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] model_read(input logic [2:0] a);
    logic [31:0] r;
    r = '0;
    case (a)
      3'd0: r[N-1:0] = m_stable;
      3'd1: r[N-1:0] = m_cap;
      3'd2: r[N-1:0] = m_mask;
      3'd3: begin
        for (int i = 0; i < int'(N); i++) begin
          if (m_cap[i] && m_mask[i]) begin
            r = 32'h8000_0000 | 32'(i);
            break;
          end
        end
      end
      3'd4: r = m_thresh;
      3'd5: r[N-1:0] = m_edge;
      default: r = '0;
    endcase
    return r;
  endfunction

  task automatic model_step(input logic [2:0] a, input logic cs, input logic wn,
                            input logic [31:0] wd, input logic [N-1:0] inp, input logic rst);
    logic [N-1:0] s2, nstable, setb;
    if (rst) begin
      m_stable = '0;
      m_cap    = '0;
      m_mask   = '0;
      m_edge   = '0;
      m_thresh = DB_DEFAULT;
      for (int i = 0; i < int'(N); i++) m_run[i] = 0;
      m_hist.delete();
      m_hist.push_back('0);
      m_hist.push_back('0);
      m_rd  = '0;
      m_irq = 1'b0;
      return;
    end
    m_rd  = model_read(a);
    m_irq = |(m_cap & m_mask);
    s2 = m_hist.pop_front();
    m_hist.push_back(inp);
    nstable = m_stable;
    setb    = '0;
    for (int i = 0; i < int'(N); i++) begin
      if (s2[i] == m_stable[i]) begin
        m_run[i] = 0;
      end else begin
        m_run[i]++;
        if (m_run[i] > m_thresh) begin
          nstable[i] = s2[i];
          m_run[i]   = 0;
          // rising counts when cfg=0, falling when cfg=1
          if (s2[i] != m_edge[i]) setb[i] = 1'b1;
        end
      end
    end
    if (cs && !wn) begin
      case (a)
        3'd1: m_cap    = m_cap & ~wd[N-1:0];
        3'd2: m_mask   = wd[N-1:0];
        3'd4: m_thresh = 32'(wd[DB_W-1:0]);
        3'd5: m_edge   = wd[N-1:0];
        default: ;
      endcase
    end
    m_cap    = m_cap | setb;
    m_stable = nstable;
  endtask

  // One clock: drive, advance the model, check after the edge.
  task automatic cyc(input logic [2:0] a, input logic cs, input logic wn,
                     input logic [31:0] wd, input logic rst);
    address    = a;
    chipselect = cs;
    write_n    = wn;
    writedata  = wd;
    in_port    = cur_in;
    reset      = rst;
    model_step(a, cs, wn, wd, cur_in, rst);
    @(posedge clk);
    #1;
    chk("model_readdata", readdata, m_rd);
    chk("model_irq", {31'b0, irq}, {31'b0, m_irq});
  endtask

  task automatic idle();
    cyc(3'd0, 1'b0, 1'b1, 32'h0, 1'b0);
  endtask

  task automatic rd(input logic [2:0] a);
    cyc(a, 1'b1, 1'b1, 32'h0, 1'b0);
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    cyc(a, 1'b1, 1'b0, d, 1'b0);
  endtask

  initial begin
    // Reset read-back table
    tab[0] = '{addr: 3'd0, exp: 32'h0};
    tab[1] = '{addr: 3'd1, exp: 32'h0};
    tab[2] = '{addr: 3'd2, exp: 32'h0};
    tab[3] = '{addr: 3'd3, exp: 32'h0};
    tab[4] = '{addr: 3'd4, exp: 32'd1000};
    tab[5] = '{addr: 3'd5, exp: 32'h0};
    tab[6] = '{addr: 3'd6, exp: 32'h0};
    tab[7] = '{addr: 3'd7, exp: 32'h0};

    cyc(3'd0, 1'b0, 1'b1, 32'h0, 1'b1);
    cyc(3'd0, 1'b0, 1'b1, 32'h0, 1'b1);
    chk("reset_irq", {31'b0, irq}, 32'h0);
    for (int i = 0; i < 8; i++) begin
      rd(tab[i].addr);
      chk("reset_readback", readdata, tab[i].exp);
      chk("reset_readback_irq", {31'b0, irq}, 32'h0);
    end

    // Debounce: 4-cycle pulse is rejected, held level lands after 2+5 edges
    wr(3'd4, 32'd4);
    cur_in = 8'h01;
    repeat (4) idle();
    cur_in = 8'h00;
    repeat (10) idle();
    rd(3'd0);
    chk("glitch_data", readdata, 32'h0);
    rd(3'd1);
    chk("glitch_capture", readdata, 32'h0);
    cur_in = 8'h01;
    repeat (7) rd(3'd0);
    chk("debounce_data_before", readdata, 32'h0);
    rd(3'd0);
    chk("debounce_data_after", readdata, 32'h1);
    rd(3'd1);
    chk("debounce_capture", readdata, 32'h1);

    // Interrupt and W1C
    wr(3'd1, 32'h1);
    wr(3'd2, 32'h1);
    wr(3'd4, 32'h0);
    cur_in = 8'h00;
    repeat (5) idle();
    cur_in = 8'h01;
    repeat (3) idle();
    chk("irq_before", {31'b0, irq}, 32'h0);
    idle();
    chk("irq_asserted", {31'b0, irq}, 32'h1);
    wr(3'd1, 32'h0);
    idle();
    chk("w1c_zero_irq", {31'b0, irq}, 32'h1);
    rd(3'd1);
    chk("w1c_zero_capture", readdata, 32'h1);
    wr(3'd1, 32'h1);
    chk("w1c_irq_same", {31'b0, irq}, 32'h1);
    idle();
    chk("w1c_irq_drop", {31'b0, irq}, 32'h0);

    // Priority
    wr(3'd2, 32'hFF);
    cur_in = cur_in | 8'h24;
    repeat (5) idle();
    rd(3'd3);
    chk("pending_ch2", readdata, 32'h8000_0002);
    chk("pending_irq", {31'b0, irq}, 32'h1);
    wr(3'd1, 32'h04);
    rd(3'd3);
    chk("pending_ch5", readdata, 32'h8000_0005);
    wr(3'd1, 32'h20);
    rd(3'd3);
    chk("pending_none", readdata, 32'h0);
    chk("pending_none_irq", {31'b0, irq}, 32'h0);

    // Edge polarity and set/W1C collision
    wr(3'd5, 32'h08);
    cur_in[3] = 1'b1;
    repeat (5) idle();
    rd(3'd1);
    chk("falling_cfg_rise_ignored", readdata, 32'h0);
    chk("falling_cfg_rise_irq", {31'b0, irq}, 32'h0);
    cur_in[3] = 1'b0;
    idle();
    idle();
    wr(3'd1, 32'h08);
    rd(3'd1);
    chk("collision_set_wins", readdata, 32'h08);
    chk("collision_irq", {31'b0, irq}, 32'h1);

    // Mid-operation reset
    wr(3'd4, 32'd20);
    cur_in[1] = 1'b1;
    repeat (6) idle();
    chk("pre_reset_irq", {31'b0, irq}, 32'h1);
    cyc(3'd0, 1'b0, 1'b1, 32'h0, 1'b1);
    chk("midreset_irq", {31'b0, irq}, 32'h0);
    chk("midreset_readdata", readdata, 32'h0);
    wr(3'd4, 32'd3);
    repeat (5) rd(3'd0);
    chk("restart_data_before", readdata, 32'h0);
    rd(3'd0);
    chk("restart_data_after", readdata, 32'h27);
    rd(3'd1);
    chk("restart_capture", readdata, 32'h27);

    // Random traffic against the model
    cyc(3'd0, 1'b0, 1'b1, 32'h0, 1'b1);
    for (int k = 0; k < 4000; k++) begin
      logic [2:0]  a;
      logic        cs, wn, rst;
      logic [31:0] d;
      a   = 3'($urandom_range(0, 7));
      cs  = 1'($urandom_range(0, 1));
      wn  = ($urandom_range(0, 2) != 0);
      d   = $urandom;
      if (a == 3'd4) d = $urandom_range(0, 6);
      rst = ($urandom_range(0, 599) == 0);
      for (int i = 0; i < int'(N); i++) begin
        if ($urandom_range(0, 11) == 0) cur_in[i] = ~cur_in[i];
      end
      cyc(a, cs, wn, d, rst);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
